// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked instruction decode with illegal-opcode
// detection, flush, and a saturating illegal-instruction counter.
// Optional build macro DECODE_SKID_EN adds a one-entry skid buffer and makes
// in_ready a register (no combinational out_ready -> in_ready path).
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int PC_W       = 32,
    parameter int ID_W       = 6,
    parameter int CNT_W      = 16,
    parameter bit ZEXT_LOGIC = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ir,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ID_W-1:0]  out_id,
    output logic [XLEN-1:0]  out_rs,
    output logic [XLEN-1:0]  out_rt,
    output logic [XLEN-1:0]  out_rd,
    output logic [PC_W-1:0]  out_pc,
    output logic [5:0]       out_sys,
    output logic             out_illegal,
    output logic [CNT_W-1:0] ill_count
);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] rs;
        logic [XLEN-1:0] rt;
        logic [XLEN-1:0] rd;
        logic [PC_W-1:0] pc;
        logic [5:0]      sys;
        logic            illegal;
    } res_t;

    logic [5:0]      op, f;
    logic [XLEN-1:0] r_rs, r_rt, r_rd, simm, zimm, jtgt, limm;
    res_t            dec, res_q;
    logic [CNT_W-1:0] cnt_q;
    logic            vld_q, acc, pop;

    assign op   = in_ir[31:26];
    assign f    = in_ir[5:0];
    assign r_rs = XLEN'(in_ir[25:21]);
    assign r_rt = XLEN'(in_ir[20:16]);
    assign r_rd = XLEN'(in_ir[15:11]);
    assign simm = {{(XLEN-16){in_ir[15]}}, in_ir[15:0]};
    assign zimm = XLEN'(in_ir[15:0]);
    assign jtgt = XLEN'(in_ir[25:0]);
    assign limm = ZEXT_LOGIC ? zimm : simm;

    // Decode the incoming word; every field not used by the encoding stays 0.
    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        unique case (op)
            6'd0: begin
                if (f <= 6'd3) begin
                    dec.id = ID_W'(f + 6'd1);
                    dec.rs = r_rs; dec.rt = r_rt; dec.rd = r_rd;
                end else dec.illegal = 1'b1;
            end
            6'd1, 6'd2: begin
                dec.id = ID_W'(op + 6'd4);
                dec.rs = r_rs; dec.rt = simm; dec.rd = r_rt;
            end
            6'd3, 6'd4: begin
                if (f == 6'd0) begin
                    dec.id = ID_W'(op + 6'd4);
                    dec.rs = r_rs; dec.rt = r_rt; dec.rd = r_rd;
                end else dec.illegal = 1'b1;
            end
            6'd5, 6'd6: begin
                dec.id = ID_W'(op + 6'd4);
                dec.rt = limm;
            end
            6'd7: begin
                if (f <= 6'd1) begin
                    dec.id = ID_W'(f + 6'd11);
                    dec.rt = zimm;
                end else dec.illegal = 1'b1;
            end
            6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd20: begin
                dec.id = ID_W'(op + 6'd5);
                dec.rt = simm; dec.rd = r_rt;
            end
            6'd16, 6'd17, 6'd18: begin
                dec.id = ID_W'(op + 6'd5);
                dec.rs = jtgt;
            end
            6'd19: begin
                dec.id = ID_W'(6'd24);
                dec.rs = r_rs; dec.rt = r_rt; dec.rd = r_rd;
            end
            6'd21: begin
                dec.id  = ID_W'(6'd26);
                dec.sys = f;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign acc = in_valid && in_ready;
    assign pop = vld_q && out_ready;

    // Illegal counter: counts accepted, non-flushed illegal words; saturates.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (acc && !flush && dec.illegal && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
    end

`ifdef DECODE_SKID_EN
    res_t skid_q;
    logic skid_vld, rdy_q;

    assign in_ready = rdy_q;

    // Output/skid occupancy: stalled accepts park in the skid, which drains first.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b0;
            res_q    <= '0;
        end else if (flush) begin
            vld_q    <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            rdy_q <= 1'b1;
            if (skid_vld) begin
                if (pop) begin
                    res_q    <= skid_q;
                    skid_vld <= 1'b0;
                end else rdy_q <= 1'b0;
            end else if (acc) begin
                if (!vld_q || pop) begin
                    res_q <= dec;
                    vld_q <= 1'b1;
                end else begin
                    skid_vld <= 1'b1;
                    rdy_q    <= 1'b0;
                end
            end else if (pop) vld_q <= 1'b0;
        end
    end

    // Skid payload: captured only when a stalled accept parks there.
    always_ff @(posedge clk) begin
        if (!skid_vld && acc && vld_q && !pop) skid_q <= dec;
    end
`else
    assign in_ready = !vld_q || out_ready;

    // Single output register: load on accept, clear valid when consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            res_q <= '0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (acc) begin
            res_q <= dec;
            vld_q <= 1'b1;
        end else if (pop) begin
            vld_q <= 1'b0;
        end
    end
`endif

    assign out_valid   = vld_q;
    assign out_id      = res_q.id;
    assign out_rs      = res_q.rs;
    assign out_rt      = res_q.rt;
    assign out_rd      = res_q.rd;
    assign out_pc      = res_q.pc;
    assign out_sys     = res_q.sys;
    assign out_illegal = res_q.illegal;
    assign ill_count   = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps plus random traffic, checked against
// a spec-level decode function and a result queue.
module tb_decode_stage;
    localparam int XL = 64;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_ir = '0, in_pc = '0;
    logic        in_ready, out_valid, out_illegal;
    logic [5:0]  out_id, out_sys;
    logic [XL-1:0] out_rs, out_rt, out_rd;
    logic [31:0] out_pc;
    logic [15:0] ill_count;
    // small-counter instance, only its counter is checked
    logic        s_in_ready, s_out_valid, s_out_illegal;
    logic [5:0]  s_out_id, s_out_sys;
    logic [XL-1:0] s_out_rs, s_out_rt, s_out_rd;
    logic [31:0] s_out_pc;
    logic [1:0]  s_ill_count;

    decode_stage #(.XLEN(XL), .PC_W(32), .ID_W(6), .CNT_W(16), .ZEXT_LOGIC(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_pc(out_pc), .out_sys(out_sys), .out_illegal(out_illegal), .ill_count(ill_count));

    decode_stage #(.XLEN(XL), .PC_W(32), .ID_W(6), .CNT_W(2), .ZEXT_LOGIC(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_ir(in_ir), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_id(s_out_id), .out_rs(s_out_rs), .out_rt(s_out_rt), .out_rd(s_out_rd),
        .out_pc(s_out_pc), .out_sys(s_out_sys), .out_illegal(s_out_illegal), .ill_count(s_ill_count));

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] rs, rt, rd;
        int          sys;
        bit          ill;
        logic [31:0] pc;
    } exp_t;

    int   checks = 0, failures = 0;
    exp_t q[$];
    int   cnt = 0;
    bit   just_reset = 1'b1;

    // Reference decode from the encoding table, using plain integer arithmetic.
    function automatic exp_t ref_dec(logic [31:0] ir, logic [31:0] pc);
        exp_t e;
        int op, f;
        longint simm;
        logic [63:0] rsf, rtf, rdf, zimm, jt;
        op   = int'(ir >> 26);
        f    = int'(ir % 64);
        rsf  = 64'((ir >> 21) % 32);
        rtf  = 64'((ir >> 16) % 32);
        rdf  = 64'((ir >> 11) % 32);
        zimm = 64'(ir % 65536);
        jt   = 64'(ir % (1 << 26));
        simm = longint'(ir % 65536);
        if (simm >= 32768) simm = simm - 65536;
        e.id = 0; e.rs = '0; e.rt = '0; e.rd = '0; e.sys = 0; e.ill = 1'b0; e.pc = pc;
        if (op == 0 && f <= 3) begin
            e.id = f + 1; e.rs = rsf; e.rt = rtf; e.rd = rdf;
        end else if ((op == 3 || op == 4) && f == 0) begin
            e.id = op + 4; e.rs = rsf; e.rt = rtf; e.rd = rdf;
        end else if (op == 1 || op == 2) begin
            e.id = op + 4; e.rs = rsf; e.rt = 64'(simm); e.rd = rtf;
        end else if (op == 5 || op == 6) begin
            e.id = op + 4; e.rt = zimm;
        end else if (op == 7 && f <= 1) begin
            e.id = 11 + f; e.rt = zimm;
        end else if ((op >= 8 && op <= 15) || op == 20) begin
            e.id = op + 5; e.rt = 64'(simm); e.rd = rtf;
        end else if (op >= 16 && op <= 18) begin
            e.id = op + 5; e.rs = jt;
        end else if (op == 19) begin
            e.id = 24; e.rs = rsf; e.rt = rtf; e.rd = rdf;
        end else if (op == 21) begin
            e.id = 26; e.sys = f;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check against model just before the edge, update model.
    task automatic cyc(input bit r, input bit v, input logic [31:0] ir, input logic [31:0] pc,
                       input bit ordy, input bit fl, output bit acc);
        bit   exp_rdy, pop;
        exp_t e;
        rst = r; in_valid = v; in_ir = ir; in_pc = pc; out_ready = ordy; flush = fl;
        #3;
`ifdef DECODE_SKID_EN
        exp_rdy = (q.size() < 2) && !just_reset;
`else
        exp_rdy = (q.size() == 0) || ordy;
`endif
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            e = q[0];
            chk("out_id", 64'(out_id), 64'(e.id));
            chk("out_rs", out_rs, e.rs);
            chk("out_rt", out_rt, e.rt);
            chk("out_rd", out_rd, e.rd);
            chk("out_pc", 64'(out_pc), 64'(e.pc));
            chk("out_sys", 64'(out_sys), 64'(e.sys));
            chk("out_illegal", 64'(out_illegal), 64'(e.ill));
        end
        chk("ill_count", 64'(ill_count), 64'(cnt));
        chk("ill_count_sat", 64'(s_ill_count), 64'((cnt > 3) ? 3 : cnt));
        acc = v && exp_rdy && !r;
        pop = (q.size() != 0) && ordy;
        if (r) begin
            q.delete(); cnt = 0; just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            if (fl) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) begin
                    e = ref_dec(ir, pc);
                    q.push_back(e);
                    if (e.ill) cnt++;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] r;
        logic [5:0]  op, f;
        r  = $urandom();
        op = 6'($urandom_range(0, 25));
        f  = 6'($urandom_range(0, 5));
        if ($urandom_range(0, 9) == 0) return r;
        return {op, r[25:6], f};
    endfunction

    logic [31:0] bp_words [4];
    bit          bp_rdy [4];

    initial begin : main
        bit acc;
        int idx;
        @(posedge clk); #1;
        // reset held for a second edge with a word offered
        cyc(1, 1, 32'h00221801, 32'h10, 0, 0, acc);
        chk("rst_out_id", 64'(out_id), 64'd0);
        chk("rst_out_rs", out_rs, 64'd0);
        chk("rst_out_rt", out_rt, 64'd0);
        chk("rst_out_rd", out_rd, 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_sys", 64'(out_sys), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst_ill_count", 64'(ill_count), 64'd0);
        cyc(0, 0, 0, 0, 1, 0, acc);   // skid build needs this cycle for in_ready

        // decode sweep with fixed expectations
        cyc(0, 1, 32'h00221801, 32'h100, 1, 0, acc);
        chk("sub_id", 64'(out_id), 64'd2);
        chk("sub_rd", out_rd, 64'd3);
        cyc(0, 1, 32'h0485FFFF, 32'h104, 1, 0, acc);
        chk("addi_rt", out_rt, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_id", 64'(out_id), 64'd5);
        cyc(0, 1, 32'h18078000, 32'h108, 1, 0, acc);
        chk("ori_rt", out_rt, 64'h8000);
        cyc(0, 1, 32'h43FFFFFF, 32'h10C, 1, 0, acc);
        chk("j_id", 64'(out_id), 64'd21);
        chk("j_rs", out_rs, 64'h3FF_FFFF);
        cyc(0, 1, 32'hFC000000, 32'h110, 1, 0, acc);
        cyc(0, 1, 32'h00000004, 32'h114, 1, 0, acc);
        chk("ill_id", 64'(out_id), 64'd0);
        chk("ill_flag", 64'(out_illegal), 64'd1);
        chk("ill_pc", 64'(out_pc), 64'h114);
        cyc(0, 0, 0, 0, 1, 0, acc);
        chk("ill_count_two", 64'(ill_count), 64'd2);

        // five more illegal words: small counter must pin at 3
        for (int i = 0; i < 5; i++) cyc(0, 1, 32'h00000007, 32'h200 + 32'(i), 1, 0, acc);
        cyc(0, 0, 0, 0, 1, 0, acc);
        chk("sat_count", 64'(s_ill_count), 64'd3);

        // back-pressure: out_ready 1,0,0,1 repeating while streaming 4 words
        bp_words[0] = 32'h00A52020; bp_words[1] = 32'h20A5FFF0;
        bp_words[2] = 32'h54000001; bp_words[3] = 32'h4C001234;
        bp_rdy[0] = 1; bp_rdy[1] = 0; bp_rdy[2] = 0; bp_rdy[3] = 1;
        idx = 0;
        for (int k = 0; k < 16 && idx < 4; k++) begin
            cyc(0, 1, bp_words[idx], 32'h300 + 32'(idx), bp_rdy[k % 4], 0, acc);
            if (acc) idx++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd4);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, bp_rdy[k], 0, acc);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0, acc);

        // flush with a held result and a concurrent illegal handshake
        cyc(0, 1, 32'h00221801, 32'h400, 0, 0, acc);
        cyc(0, 1, 32'hF8000000, 32'h404, 1, 1, acc);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_count", 64'(ill_count), 64'(cnt));

        // full rate: 16 back-to-back words
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, rnd_word(), 32'h500 + 32'(4 * i), 1, 0, acc);
            if (acc) idx++;
        end
        chk("full_rate_accepts", 64'(idx), 64'd16);
        cyc(0, 0, 0, 0, 1, 0, acc);

        // random traffic, including stalls and occasional flushes
        for (int i = 0; i < 400; i++)
            cyc(0, $urandom_range(0, 3) != 0, rnd_word(), $urandom(),
                $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, acc);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
